// File: rtl/pe_inject_sched.sv
// Round-robin injection scheduler: stamps granted payloads with {src, table dst} and queues them for the switch PE port.
// Optional INJ_STALL_CNT_EN adds a saturating PE back-pressure stall counter (stall_clr / stall_cnt).
module pe_inject_sched #(
  parameter int NUM_REQ     = 4,
  parameter int data_width  = 8,
  parameter int x_size      = 2,
  parameter int y_size      = 2,
  parameter int x_coord     = 3,
  parameter int y_coord     = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int total_width = 2*x_size + 2*y_size + data_width
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*data_width-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            cfg_we,
  input  logic [2:0]                      cfg_idx,
  input  logic [x_size+y_size-1:0]        cfg_dst,
  output logic                            o_valid_pe,
  output logic [total_width-1:0]          o_data_pe,
  input  logic                            i_ready_pe,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            idle
`ifdef INJ_STALL_CNT_EN
  ,
  input  logic                            stall_clr,
  output logic [15:0]                     stall_cnt
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = x_size + y_size;

  logic [DW-1:0]          r_tab [NUM_REQ];
  logic [total_width-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr;
  logic [AW-1:0]          r_rd;
  logic [CW-1:0]          r_count;
  logic [PW-1:0]          r_ptr;

  logic [NUM_REQ-1:0]     w_grant;
  logic [PW-1:0]          w_gidx;
  logic [PW-1:0]          w_cand;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic [total_width-1:0] w_flit;

  // No fall-through: a full FIFO refuses grants even if the head pops this cycle.
  assign w_full = (r_count == CW'(FIFO_DEPTH));

  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = r_ptr + PW'(k);
      if (rstn && !w_full && (w_grant == '0) && req_valid[w_cand]) begin
        w_grant[w_cand] = 1'b1;
        w_gidx          = w_cand;
      end
    end
  end

  assign req_ready = w_grant;
  assign w_push    = |w_grant;
  assign w_pop     = (r_count != '0) && i_ready_pe;
  assign w_flit    = {req_data[w_gidx*data_width +: data_width],
                      x_size'(x_coord), y_size'(y_coord), r_tab[w_gidx]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ptr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      for (int i = 0; i < NUM_REQ; i++)    r_tab[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_flit;
        r_wr        <= r_wr + AW'(1);
        r_ptr       <= w_gidx + PW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      // Grant above already read the old entry, so a same-cycle write only affects later flits.
      if (cfg_we && (32'(cfg_idx) < NUM_REQ)) r_tab[cfg_idx[PW-1:0]] <= cfg_dst;
    end
  end

  assign o_valid_pe = (r_count != '0);
  assign o_data_pe  = r_mem[r_rd];
  assign fifo_count = r_count;
  assign idle       = (r_count == '0) && !(|req_valid);

`ifdef INJ_STALL_CNT_EN
  logic [15:0] r_stall;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                                   r_stall <= '0;
    else if (stall_clr)                                          r_stall <= '0;
    else if (o_valid_pe && !i_ready_pe && (r_stall != 16'hFFFF)) r_stall <= r_stall + 16'd1;
  end
  assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_pe_inject_sched.sv
// Scoreboarded bench for pe_inject_sched: grants, flit stamping, back-pressure, async reset, table writes.
module tb_pe_inject_sched;
  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [3:0]  cfg_dst;
  logic        o_valid_pe;
  logic [15:0] o_data_pe;
  logic        i_ready_pe;
  logic [2:0]  fifo_count;
  logic        idle;
`ifdef INJ_STALL_CNT_EN
  logic        stall_clr;
  logic [15:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] sbq [$];
  logic [3:0]  tab [4];

  always #5 clk = ~clk;

  pe_inject_sched dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_dst(cfg_dst),
    .o_valid_pe(o_valid_pe), .o_data_pe(o_data_pe), .i_ready_pe(i_ready_pe),
    .fifo_count(fifo_count), .idle(idle)
`ifdef INJ_STALL_CNT_EN
    , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
  );

  // Scoreboard: push the expected flit on every handshake, compare on every pop.
  always @(negedge clk) begin
    if (!rstn) begin
      sbq.delete();
      for (int i = 0; i < 4; i++) tab[i] = 4'h0;
    end else begin
      if (o_valid_pe && i_ready_pe) begin
        n_checks++;
        if (sbq.size() == 0) $display("FAIL pop_unexpected got=%h want=<none>", o_data_pe);
        else begin
          logic [15:0] exp_flit;
          exp_flit = sbq.pop_front();
          if (o_data_pe !== exp_flit) $display("FAIL pop_data got=%h want=%h", o_data_pe, exp_flit);
          else n_pass++;
        end
      end
      if (req_valid != 4'b0) begin
        n_checks++;
        if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != 4'b0))
          $display("FAIL grant_shape got=%b valid=%b want=onehot0_within_valid", req_ready, req_valid);
        else n_pass++;
      end
      for (int i = 0; i < 4; i++)
        if (req_ready[i] && req_valid[i]) sbq.push_back({req_data[i*8 +: 8], 2'd3, 2'd1, tab[i]});
      if (cfg_we && cfg_idx < 3'd4) tab[cfg_idx[1:0]] = cfg_dst;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    req_valid  = 4'b0;
    i_ready_pe = 1'b1;
    while (fifo_count != 3'd0 && n < 20) begin cyc(); n++; end
    n_checks++;
    if (fifo_count !== 3'd0) $display("FAIL drain_timeout got=%0d want=0", fifo_count);
    else n_pass++;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 4'b1111; req_data = 32'h0; cfg_we = 1'b0;
    cfg_idx = 3'd0; cfg_dst = 4'h0; i_ready_pe = 1'b0;
`ifdef INJ_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    cyc(); #1;
    n_checks++; if (req_ready !== 4'b0) $display("FAIL rst_req_ready got=%b want=0000", req_ready); else n_pass++;
    n_checks++; if (o_valid_pe !== 1'b0) $display("FAIL rst_valid got=%b want=0", o_valid_pe); else n_pass++;
    n_checks++; if (o_data_pe !== 16'h0) $display("FAIL rst_data got=%h want=0000", o_data_pe); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL rst_count got=%0d want=0", fifo_count); else n_pass++;
    req_valid = 4'b0; #1;
    n_checks++; if (idle !== 1'b1) $display("FAIL rst_idle got=%b want=1", idle); else n_pass++;
    cyc();
    rstn = 1'b1;
  endtask

  task automatic test_single();
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_dst = {2'd2, 2'd1};
    cyc();
    cfg_we = 1'b0; req_valid = 4'b0001; req_data[7:0] = 8'hA5; i_ready_pe = 1'b1; #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_grant got=%b want=0001", req_ready); else n_pass++;
    cyc();
    req_valid = 4'b0; #1;
    n_checks++; if (o_valid_pe !== 1'b1) $display("FAIL single_valid got=%b want=1", o_valid_pe); else n_pass++;
    n_checks++; if (o_data_pe !== 16'hA5D9) $display("FAIL single_flit got=%h want=a5d9", o_data_pe); else n_pass++;
    cyc();
    n_checks++; if (o_valid_pe !== 1'b0) $display("FAIL single_after got=%b want=0", o_valid_pe); else n_pass++;
  endtask

  task automatic test_round_robin();
    pulse_reset();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
    req_valid = 4'b1111; i_ready_pe = 1'b1; #1;
    for (int c = 0; c < 6; c++) begin
      logic [3:0] want;
      want = 4'b0001 << (c % 4);
      n_checks++;
      if (req_ready !== want) $display("FAIL rr_grant%0d got=%b want=%b", c, req_ready, want); else n_pass++;
      cyc();
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [15:0] head;
    pulse_reset();
    i_ready_pe = 1'b0; req_valid = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      req_data[7:0] = 8'h40 + 8'(c); #1;
      n_checks++;
      if (req_ready !== 4'b0001) $display("FAIL bp_grant%0d got=%b want=0001", c, req_ready); else n_pass++;
      cyc();
    end
    req_data[7:0] = 8'h44; #1;
    n_checks++; if (fifo_count !== 3'd4) $display("FAIL bp_full_count got=%0d want=4", fifo_count); else n_pass++;
    n_checks++; if (req_ready !== 4'b0) $display("FAIL bp_full_ready got=%b want=0000", req_ready); else n_pass++;
    n_checks++; if (o_data_pe !== 16'h40D0) $display("FAIL bp_head got=%h want=40d0", o_data_pe); else n_pass++;
    head = o_data_pe;
    cyc(); cyc();
    n_checks++;
    if (o_data_pe !== 16'h40D0 || o_valid_pe !== 1'b1)
      $display("FAIL bp_stable got=%h/%b want=40d0/1", o_data_pe, o_valid_pe);
    else n_pass++;
    i_ready_pe = 1'b1; #1;
    n_checks++; if (req_ready !== 4'b0) $display("FAIL bp_no_fallthru got=%b want=0000", req_ready); else n_pass++;
    cyc();
    n_checks++; if (fifo_count !== 3'd3) $display("FAIL bp_first_pop got=%0d want=3", fifo_count); else n_pass++;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL bp_resume got=%b want=0001", req_ready); else n_pass++;
    cyc();
    drain();
  endtask

  task automatic test_simul_push_pop();
    i_ready_pe = 1'b0; req_valid = 4'b0001;
    req_data[7:0] = 8'h60; cyc();
    req_data[7:0] = 8'h61; cyc();
    req_data[7:0] = 8'h62; i_ready_pe = 1'b1; #1;
    n_checks++; if (fifo_count !== 3'd2) $display("FAIL sp_pre_count got=%0d want=2", fifo_count); else n_pass++;
    cyc();
    req_valid = 4'b0; i_ready_pe = 1'b0; #1;
    n_checks++; if (fifo_count !== 3'd2) $display("FAIL sp_count got=%0d want=2", fifo_count); else n_pass++;
    n_checks++; if (o_data_pe !== 16'h61D0) $display("FAIL sp_head got=%h want=61d0", o_data_pe); else n_pass++;
    drain();
  endtask

  task automatic test_async_reset();
    i_ready_pe = 1'b0; req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin req_data[7:0] = 8'h70 + 8'(c); cyc(); end
    req_valid = 4'b0;
    @(posedge clk); #3;
    rstn = 1'b0; #1;
    n_checks++; if (o_valid_pe !== 1'b0) $display("FAIL ar_valid got=%b want=0", o_valid_pe); else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL ar_count got=%0d want=0", fifo_count); else n_pass++;
    cyc();
    rstn = 1'b1; i_ready_pe = 1'b1;
    cyc();
    n_checks++; if (o_valid_pe !== 1'b0) $display("FAIL ar_after got=%b want=0", o_valid_pe); else n_pass++;
  endtask

  task automatic test_cfg();
    req_valid = 4'b0010; req_data[15:8] = 8'h81; i_ready_pe = 1'b1;
    cfg_we = 1'b1; cfg_idx = 3'd1; cfg_dst = {2'd0, 2'd2}; #1;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL cfg_grant got=%b want=0010", req_ready); else n_pass++;
    cyc();
    cfg_we = 1'b0; req_data[15:8] = 8'h82; #1;
    n_checks++; if (o_data_pe !== 16'h81D0) $display("FAIL cfg_old_dst got=%h want=81d0", o_data_pe); else n_pass++;
    cyc();
    req_valid = 4'b0; #1;
    n_checks++; if (o_data_pe !== 16'h82D2) $display("FAIL cfg_new_dst got=%h want=82d2", o_data_pe); else n_pass++;
    cyc();
    cfg_we = 1'b1; cfg_idx = 3'd5; cfg_dst = 4'hF;
    cyc();
    cfg_we = 1'b0; req_valid = 4'b0010; req_data[15:8] = 8'h83;
    cyc();
    req_valid = 4'b0; #1;
    n_checks++; if (o_data_pe !== 16'h83D2) $display("FAIL cfg_idx5_ignored got=%h want=83d2", o_data_pe); else n_pass++;
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_simul_push_pop();
    test_async_reset();
    test_cfg();
    cyc();
    n_checks++;
    if (sbq.size() != 0) $display("FAIL sb_leftover got=%0d want=0", sbq.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
